mochila_mem_xbar: RTL



---
 rtl/mochila_mem_xbar_pkg.sv | 35 +++
 rtl/mochila_mem_xbar_if.sv | 33 +++
 rtl/mochila_rr_arbiter.sv | 60 ++++++
 rtl/mochila_mem_xbar.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mochila_mem_xbar_pkg.sv
`default_nettype none
// ============================================================================
// Module : mochila_mem_xbar_pkg
// Brief  : OBI bus types and crossbar defaults for the Mochila memory path.
// Rev    : 1.0 - initial release
// ============================================================================
package mochila_mem_xbar_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  localparam int unsigned c_xbar_n_masters  = 4;
  localparam int unsigned c_xbar_n_banks    = 2;
  localparam logic [31:0] c_xbar_bank_size  = 32'h0000_8000;
  localparam logic [31:0] c_xbar_base_addr  = 32'h0000_0000;
  localparam logic [31:0] c_xbar_err_rdata  = 32'hBADC_AB1E;

  // Index width that stays legal (>=1 bit) for single-entry vectors.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mochila_mem_xbar_if.sv
`default_nettype none
// ============================================================================
// Module : mochila_mem_xbar_if
// Brief  : Master-side and bank-side OBI bundles of the memory crossbar.
// Rev    : 1.0 - initial release
// ============================================================================
interface mochila_mem_xbar_if #(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned N_BANKS   = 2
);
  import mochila_mem_xbar_pkg::*;

  obi_req_t  master_req_i  [N_MASTERS];
  obi_resp_t master_resp_o [N_MASTERS];
  obi_req_t  bank_req_o    [N_BANKS];
  obi_resp_t bank_resp_i   [N_BANKS];

  modport slave (
    input  master_req_i,
    output master_resp_o,
    output bank_req_o,
    input  bank_resp_i
  );

  modport master (
    output master_req_i,
    input  master_resp_o,
    input  bank_req_o,
    output bank_resp_i
  );

endinterface
`default_nettype wire

// File: rtl/mochila_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mochila_rr_arbiter
// Brief  : N-input round-robin arbiter, one-hot grant, pointer moves on ack.
// Rev    : 1.0 - initial release
// ============================================================================
module mochila_rr_arbiter
  import mochila_mem_xbar_pkg::*;
#(
  parameter  int unsigned N       = 4,
  localparam int unsigned c_idx_w = idx_width(N)
) (
  input  wire logic               clk_i,
  input  wire logic               rst_ni,
  input  wire logic [N-1:0]       i_req,
  input  wire logic               i_ack,
  output logic      [N-1:0]       o_gnt,
  output logic      [c_idx_w-1:0] o_idx
);

  generate
    if (N == 1) begin : g_single
      logic w_unused;
      assign w_unused = i_ack ^ clk_i ^ rst_ni;
      assign o_gnt    = i_req;
      assign o_idx    = '0;
    end else begin : g_rr
      logic [c_idx_w-1:0] r_ptr;
      logic               w_found;
      int unsigned        w_k;

      // Scan from the pointer, wrapping, and take the first requester.
      always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_k     = 0;
        for (int unsigned i = 0; i < N; i++) begin
          w_k = int'(r_ptr) + i;
          if (w_k >= N) w_k = w_k - N;
          if (!w_found && i_req[w_k]) begin
            w_found    = 1'b1;
            o_gnt[w_k] = 1'b1;
            o_idx      = c_idx_w'(w_k);
          end
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_ptr <= '0;
        end else if (i_ack) begin
          r_ptr <= (o_idx == c_idx_w'(N - 1)) ? '0 : o_idx + c_idx_w'(1);
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mochila_mem_xbar.sv
`default_nettype none
// ============================================================================
// Module : mochila_mem_xbar
// Brief  : OBI crossbar, N masters to N_BANKS RAM banks, per-bank round-robin.
// Rev    : 1.0 - initial release
// ============================================================================
module mochila_mem_xbar
  import mochila_mem_xbar_pkg::*;
#(
  parameter int unsigned N_MASTERS   = c_xbar_n_masters,
  parameter int unsigned N_BANKS     = c_xbar_n_banks,
  parameter logic [31:0] BANK_SIZE   = c_xbar_bank_size,
  parameter logic [31:0] BASE_ADDR   = c_xbar_base_addr,
  parameter bit          INTERLEAVED = 1'b0,
  parameter logic [31:0] ERR_RDATA   = c_xbar_err_rdata
) (
  input  wire logic          clk_i,
  input  wire logic          rst_ni,
  mochila_mem_xbar_if.slave  bus
);

  localparam int unsigned c_midx_w   = idx_width(N_MASTERS);
  localparam int unsigned c_bidx_w   = idx_width(N_BANKS);
  localparam int unsigned c_lg_banks = (N_BANKS > 1) ? $clog2(N_BANKS) : 0;
  localparam int unsigned c_lg_bsize = $clog2(BANK_SIZE);
  localparam logic [33:0] c_span     = 34'(N_BANKS) * 34'(BANK_SIZE);

  logic [31:0]           w_off      [N_MASTERS];
  logic [31:0]           w_local    [N_MASTERS];
  logic [c_bidx_w-1:0]   w_bank     [N_MASTERS];
  logic [N_MASTERS-1:0]  w_oor;
  logic [N_MASTERS-1:0]  w_cand     [N_BANKS];
  logic [N_MASTERS-1:0]  w_arb_gnt  [N_BANKS];
  logic [c_midx_w-1:0]   w_arb_idx  [N_BANKS];
  logic [N_BANKS-1:0]    w_ack;
  obi_req_t              w_bank_req [N_BANKS];
  obi_resp_t             w_mst_resp [N_MASTERS];

  logic [N_BANKS-1:0]    r_own_vld;
  logic [c_midx_w-1:0]   r_own_idx  [N_BANKS];
  logic [N_MASTERS-1:0]  r_oor_vld;

  always_comb begin
    for (int m = 0; m < N_MASTERS; m++) begin
      w_off[m] = bus.master_req_i[m].addr - BASE_ADDR;
      w_oor[m] = (bus.master_req_i[m].addr < BASE_ADDR) || ({2'b00, w_off[m]} >= c_span);
      if (INTERLEAVED) begin
        w_bank[m]  = c_bidx_w'((w_off[m] >> 2) & 32'(N_BANKS - 1));
        w_local[m] = (((w_off[m] >> (2 + c_lg_banks)) << 2) | {30'd0, w_off[m][1:0]})
                     & (BANK_SIZE - 32'd1);
      end else begin
        w_bank[m]  = c_bidx_w'((w_off[m] >> c_lg_bsize) & 32'(N_BANKS - 1));
        w_local[m] = w_off[m] & (BANK_SIZE - 32'd1);
      end
    end
  end

  // Requests are masked while in reset so nothing leaks to the banks.
  always_comb begin
    for (int b = 0; b < N_BANKS; b++) begin
      for (int m = 0; m < N_MASTERS; m++) begin
        w_cand[b][m] = rst_ni && bus.master_req_i[m].req && !w_oor[m]
                       && (w_bank[m] == c_bidx_w'(b));
      end
      w_ack[b] = (|w_cand[b]) && bus.bank_resp_i[b].gnt;
    end
  end

  generate
    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
      mochila_rr_arbiter #(
        .N (N_MASTERS)
      ) u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_req  (w_cand[b]),
        .i_ack  (w_ack[b]),
        .o_gnt  (w_arb_gnt[b]),
        .o_idx  (w_arb_idx[b])
      );
    end
  endgenerate

  always_comb begin
    for (int b = 0; b < N_BANKS; b++) begin
      w_bank_req[b] = '0;
      if (|w_cand[b]) begin
        w_bank_req[b]      = bus.master_req_i[w_arb_idx[b]];
        w_bank_req[b].addr = w_local[w_arb_idx[b]];
      end
    end
  end

  always_comb begin
    for (int m = 0; m < N_MASTERS; m++) begin
      w_mst_resp[m].gnt    = rst_ni && bus.master_req_i[m].req && w_oor[m];
      w_mst_resp[m].rvalid = r_oor_vld[m];
      w_mst_resp[m].rdata  = r_oor_vld[m] ? ERR_RDATA : 32'd0;
    end
    for (int b = 0; b < N_BANKS; b++) begin
      for (int m = 0; m < N_MASTERS; m++) begin
        if (w_arb_gnt[b][m] && bus.bank_resp_i[b].gnt) w_mst_resp[m].gnt = 1'b1;
      end
      // A bank rvalid without a registered owner is dropped here.
      if (r_own_vld[b] && bus.bank_resp_i[b].rvalid) begin
        w_mst_resp[r_own_idx[b]].rvalid = 1'b1;
        w_mst_resp[r_own_idx[b]].rdata  = bus.bank_resp_i[b].rdata;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_own_vld <= '0;
      r_oor_vld <= '0;
      for (int b = 0; b < N_BANKS; b++) r_own_idx[b] <= '0;
    end else begin
      for (int b = 0; b < N_BANKS; b++) begin
        r_own_vld[b] <= w_ack[b];
        if (w_ack[b]) r_own_idx[b] <= w_arb_idx[b];
      end
      for (int m = 0; m < N_MASTERS; m++) begin
        r_oor_vld[m] <= bus.master_req_i[m].req && w_oor[m];
      end
    end
  end

  assign bus.bank_req_o    = w_bank_req;
  assign bus.master_resp_o = w_mst_resp;

endmodule
`default_nettype wire
